// File: rtl/mul_repadd_pkg.sv
// -----------------------------------------------------------------------------
// mul_repadd_pkg
// Shared definitions for the repeated-addition multiplier:
//   - mul_state_e : controller state encoding (IDLE / ADD / DONE)
//   - MUL_REPADD_DEFAULT_WIDTH : default operand width
// -----------------------------------------------------------------------------
package mul_repadd_pkg;

    localparam int unsigned MUL_REPADD_DEFAULT_WIDTH = 16;

    // Two bits are enough for three states; the spare code is treated as
    // IDLE by the controller so a corrupted state register recovers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage : mul_repadd_pkg

// File: rtl/mul_repadd_cntr.sv
// -----------------------------------------------------------------------------
// mul_repadd_cntr
// WIDTH-bit loadable down-counter holding the remaining number of additions.
// A registered zero flag tracks "count == 0" so the controller can decide on
// the same edge whether another addition is needed, without a wide compare
// in its decision path.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset (count 0, zero flag set)
//   load_i     load load_val_i (wins over dec_i)
//   load_val_i value to load
//   dec_i      decrement by one; ignored when the count is already zero
//   zero_o     registered flag, high exactly when the count is zero
// -----------------------------------------------------------------------------
module mul_repadd_cntr
    import mul_repadd_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_REPADD_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             zero_q;
    logic             zero_d;

    // Next-state for count and zero flag: load has priority over decrement.
    always_comb begin
        count_d = count_q;
        zero_d  = zero_q;
        if (load_i) begin
            count_d = load_val_i;
            zero_d  = (load_val_i == CNT_ZERO);
        end else if (dec_i && (count_q != CNT_ZERO)) begin
            // The zero test guards the decrement so the counter never wraps.
            count_d = count_q - CNT_ONE;
            zero_d  = (count_q == CNT_ONE);
        end else begin
            count_d = count_q;
            zero_d  = zero_q;
        end
    end

    // Counter and zero-flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= CNT_ZERO;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule : mul_repadd_cntr

// File: rtl/mul_repadd_unit.sv
// -----------------------------------------------------------------------------
// mul_repadd_unit
// Unsigned multiplier by repeated addition with a start/done handshake.
// A host loads operands with a one-cycle start while the unit is idle, then
// polls busy or waits for the done pulse. The accumulator is 2*WIDTH bits so
// the full product is always representable.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    operation request, sampled only while idle
//   a_in     multiplicand (unsigned, WIDTH bits)
//   b_in     multiplier   (unsigned, WIDTH bits)
//   busy     high whenever the controller is not idle
//   done     one-cycle pulse when product is valid
//   product  2*WIDTH-bit result; holds until the next accepted start
//   cycles   number of add cycles used by the last operation
//
// Build option:
//   MUL_REPADD_SWAP_EN  when defined, the larger operand is used as the addend
//                       and the smaller as the iteration count, so the run
//                       time is min(a_in, b_in) adds. The product is the same.
// -----------------------------------------------------------------------------
module mul_repadd_unit
    import mul_repadd_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_REPADD_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH:0]     cycles
);

    localparam logic [2*WIDTH-1:0] P_ZERO   = {(2*WIDTH){1'b0}};
    localparam logic [WIDTH:0]     CYC_ZERO = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]     CYC_ONE  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   A_ZERO   = {WIDTH{1'b0}};

    mul_state_e         state_q;
    mul_state_e         state_d;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH:0]     cycles_q;
    logic               busy_q;
    logic               done_q;

    logic               accept_s;
    logic               add_s;
    logic               cnt_zero_s;
    logic [WIDTH-1:0]   load_a_s;
    logic [WIDTH-1:0]   load_c_s;

`ifdef MUL_REPADD_SWAP_EN
    // Operand steering: larger value becomes the addend, smaller the count;
    // on a tie a_in stays the addend.
    always_comb begin
        if (a_in >= b_in) begin
            load_a_s = a_in;
            load_c_s = b_in;
        end else begin
            load_a_s = b_in;
            load_c_s = a_in;
        end
    end
`else
    assign load_a_s = a_in;
    assign load_c_s = b_in;
`endif

    // Controller next-state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        add_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_d  = ST_ADD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ADD: begin
                // Zero flag reflects the count after the previous edge, so
                // exactly N adds happen before leaving this state.
                if (cnt_zero_s) begin
                    state_d = ST_DONE;
                end else begin
                    add_s   = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mul_repadd_cntr #(
        .WIDTH (WIDTH)
    ) u_cntr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (accept_s),
        .load_val_i (load_c_s),
        .dec_i      (add_s),
        .zero_o     (cnt_zero_s)
    );

    // State, flags, addend, accumulator and cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= A_ZERO;
            p_q      <= P_ZERO;
            cycles_q <= CYC_ZERO;
        end else begin
            state_q <= state_d;
            // Flags are derived from the next state so they line up with it.
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (accept_s) begin
                a_q      <= load_a_s;
                p_q      <= P_ZERO;
                cycles_q <= CYC_ZERO;
            end else if (add_s) begin
                a_q      <= a_q;
                p_q      <= p_q + {{WIDTH{1'b0}}, a_q};
                cycles_q <= cycles_q + CYC_ONE;
            end else begin
                a_q      <= a_q;
                p_q      <= p_q;
                cycles_q <= cycles_q;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = p_q;
    assign cycles  = cycles_q;

endmodule : mul_repadd_unit
